vga_uart_pic_disp: RTL and testbench

- Receives a 100x100 image as 10000 RGB332 bytes over a UART RX line (8N1) and stores it in on-chip RAM.
- Continuously drives a 640x480@60 VGA raster with the stored image in a centred window and black elsewhere.
- Top-level display block between the board UART pin and the VGA DAC/connector.

---
 rtl/vga_uart_pkg.sv | 37 +++
 rtl/vga_uart_pic_disp_uart_rx.sv | 114 +++++++++++
 rtl/vga_uart_pic_disp.sv | 130 +++++++++++++
 tb/tb_vga_uart_pic_disp.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/vga_uart_pkg.sv
// Shared constants and types for the UART-loaded VGA picture display.
// Contents: 640x480@60 raster timing (in pixel enables), image store
// capacity and address width, and the UART receiver state encoding.
package vga_uart_pkg;

   // Horizontal timing, one unit per pixel enable
   localparam int unsigned H_SYNC      = 96;
   localparam int unsigned H_BACK      = 40;
   localparam int unsigned H_LEFT      = 8;
   localparam int unsigned H_VALID     = 640;
   localparam int unsigned H_RIGHT     = 8;
   localparam int unsigned H_FRONT     = 8;
   localparam int unsigned H_TOTAL     = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
   localparam int unsigned H_ACT_START = H_SYNC + H_BACK + H_LEFT;

   // Vertical timing, one unit per line
   localparam int unsigned V_SYNC      = 2;
   localparam int unsigned V_BACK      = 25;
   localparam int unsigned V_TOP       = 8;
   localparam int unsigned V_VALID     = 480;
   localparam int unsigned V_BOTTOM    = 8;
   localparam int unsigned V_FRONT     = 2;
   localparam int unsigned V_TOTAL     = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
   localparam int unsigned V_ACT_START = V_SYNC + V_BACK + V_TOP;

   // Image store capacity (100x100 RGB332)
   localparam int unsigned PIC_SIZE   = 10000;
   localparam int unsigned PIC_ADDR_W = $clog2(PIC_SIZE);

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/vga_uart_pic_disp_uart_rx.sv
// 8N1 UART receiver with 2-FF input synchroniser and mid-bit sampling.
// Ports: clk, rst (async, active-high), rx (idle high)
//        data[7:0] - last good byte, valid - one-cycle strobe per good byte.
// A byte with a low stop bit is dropped without a strobe.
module uart_rx_8n1
   import vga_uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned UART_BPS = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid
);

   localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
   localparam int unsigned CNT_W        = $clog2(BAUD_CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_CNT_MAX / 2);

   uart_state_e      state_q, state_d;
   logic             rx_meta_q, rx_meta_d;
   logic             rx_sync_q, rx_sync_d;
   logic             rx_prev_q, rx_prev_d;
   logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             mid_c;

   // Next-state: baud counter runs only while a frame is in progress
   always_comb begin
      rx_meta_d  = rx;
      rx_sync_d  = rx_meta_q;
      rx_prev_d  = rx_sync_q;
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      mid_c      = (baud_cnt_q == CNT_MID);

      if (state_q != UART_IDLE) begin
         baud_cnt_d = (baud_cnt_q == CNT_LAST) ? '0 : baud_cnt_q + CNT_W'(1);
      end

      case (state_q)
         UART_IDLE: begin
            if (rx_prev_q && !rx_sync_q) begin
               state_d    = UART_START;
               baud_cnt_d = '0;
            end
         end
         UART_START: begin
            if (mid_c) begin
               // A start bit that is high again at mid-bit was a glitch
               state_d   = rx_sync_q ? UART_IDLE : UART_DATA;
               bit_cnt_d = 3'd0;
            end
         end
         UART_DATA: begin
            if (mid_c) begin
               shift_d   = {rx_sync_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = UART_STOP;
               end
            end
         end
         UART_STOP: begin
            if (mid_c) begin
               if (rx_sync_q) begin
                  valid_d = 1'b1;
                  data_d  = shift_q;
               end
               state_d = UART_IDLE;
            end
         end
         default: state_d = UART_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= UART_IDLE;
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         baud_cnt_q <= '0;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         data_q     <= 8'h00;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_meta_q  <= rx_meta_d;
         rx_sync_q  <= rx_sync_d;
         rx_prev_q  <= rx_prev_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
      end
   end

   assign data  = data_q;
   assign valid = valid_q;

endmodule

// File: rtl/vga_uart_pic_disp.sv
// UART-loaded picture display: bytes received on rx fill an RGB332 image
// store, which is shown in a window of a 640x480@60 raster (black elsewhere).
// Ports: sys_clk, sys_rst (async, active-high), rx (UART, idle high)
//        rgb[7:0] (RGB332), hsync, vsync (both active-high, registered).
// PIC_W*PIC_H must not exceed PIC_SIZE.
module vga_uart_pic_disp
   import vga_uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ    = 50_000_000,
   parameter int unsigned UART_BPS    = 9600,
   parameter int unsigned PIC_W       = 100,
   parameter int unsigned PIC_H       = 100,
   parameter int unsigned H_PIC_START = 270,
   parameter int unsigned V_PIC_START = 190
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       rx,
   output logic [7:0] rgb,
   output logic       hsync,
   output logic       vsync
);

   localparam int unsigned PIC_LAST = PIC_W * PIC_H - 1;
   localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
   localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
   localparam logic [9:0] H_X0       = 10'(H_ACT_START + H_PIC_START);
   localparam logic [9:0] H_X1       = 10'(H_ACT_START + H_PIC_START + PIC_W);
   localparam logic [9:0] V_Y0       = 10'(V_ACT_START + V_PIC_START);
   localparam logic [9:0] V_Y1       = 10'(V_ACT_START + V_PIC_START + PIC_H);

   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  pix_en_q, pix_en_d;
   logic [9:0]            h_cnt_q, h_cnt_d;
   logic [9:0]            v_cnt_q, v_cnt_d;
   logic [PIC_ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]            rgb_q, rgb_d;
   logic                  hsync_q, hsync_d;
   logic                  vsync_q, vsync_d;
   logic [9:0]            rel_x_c, rel_y_c;
   logic                  in_pic_c;
   logic [PIC_ADDR_W-1:0] rd_addr_c;
   logic [7:0]            rd_data_q;
   logic [7:0]            mem [PIC_SIZE];

   uart_rx_8n1 #(
      .CLK_FREQ (CLK_FREQ),
      .UART_BPS (UART_BPS)
   ) u_uart_rx (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .rx    (rx),
      .data  (rx_data),
      .valid (rx_valid)
   );

   // Picture window hit and its RAM address, from the current counters
   always_comb begin
      rel_x_c   = h_cnt_q - H_X0;
      rel_y_c   = v_cnt_q - V_Y0;
      in_pic_c  = (h_cnt_q >= H_X0) && (h_cnt_q < H_X1) &&
                  (v_cnt_q >= V_Y0) && (v_cnt_q < V_Y1);
      rd_addr_c = in_pic_c ? PIC_ADDR_W'(32'(rel_y_c) * PIC_W + 32'(rel_x_c)) : '0;
   end

   // Raster, write pointer and output next-state
   always_comb begin
      pix_en_d  = ~pix_en_q;
      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;
      wr_addr_d = wr_addr_q;
      rgb_d     = rgb_q;
      hsync_d   = hsync_q;
      vsync_d   = vsync_q;

      if (rx_valid) begin
         wr_addr_d = (wr_addr_q == PIC_ADDR_W'(PIC_LAST)) ? '0 : wr_addr_q + PIC_ADDR_W'(1);
      end

      // Counters are held through the pix_en=0 clock so the RAM read
      // issued then lines up with these same counters on pix_en=1.
      if (pix_en_q) begin
         rgb_d   = in_pic_c ? rd_data_q : 8'h00;
         hsync_d = (h_cnt_q < H_SYNC_END);
         vsync_d = (v_cnt_q < V_SYNC_END);
         if (h_cnt_q == H_MAX) begin
            h_cnt_d = 10'd0;
            v_cnt_d = (v_cnt_q == V_MAX) ? 10'd0 : v_cnt_q + 10'd1;
         end else begin
            h_cnt_d = h_cnt_q + 10'd1;
         end
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         pix_en_q  <= 1'b0;
         h_cnt_q   <= 10'd0;
         v_cnt_q   <= 10'd0;
         wr_addr_q <= '0;
         rgb_q     <= 8'h00;
         hsync_q   <= 1'b0;
         vsync_q   <= 1'b0;
      end else begin
         pix_en_q  <= pix_en_d;
         h_cnt_q   <= h_cnt_d;
         v_cnt_q   <= v_cnt_d;
         wr_addr_q <= wr_addr_d;
         rgb_q     <= rgb_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
      end
   end

   // Image store: read-before-write on a same-address collision, not reset
   always_ff @(posedge sys_clk) begin
      if (rx_valid) begin
         mem[wr_addr_q] <= rx_data;
      end
      rd_data_q <= mem[rd_addr_c];
   end

   assign rgb   = rgb_q;
   assign hsync = hsync_q;
   assign vsync = vsync_q;

endmodule

// File: tb/tb_vga_uart_pic_disp.sv
// Directed bench for vga_uart_pic_disp: 5 clocks per UART bit, a 4x2 image
// window at active column 2, row 1, so the picture rows are reached early.
module tb_vga_uart_pic_disp;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       rx      = 1'b1;
   logic [7:0] rgb;
   logic       hsync;
   logic       vsync;

   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   logic       counting = 1'b0;
   int         strobes  = 0;
   logic [7:0] last_data = 8'h00;
   int         s0;

   always #10 sys_clk = ~sys_clk;

   vga_uart_pic_disp #(
      .CLK_FREQ    (50_000),
      .UART_BPS    (9600),
      .PIC_W       (4),
      .PIC_H       (2),
      .H_PIC_START (2),
      .V_PIC_START (1)
   ) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .rx      (rx),
      .rgb     (rgb),
      .hsync   (hsync),
      .vsync   (vsync)
   );

   // Clock edges since reset release, and received-byte strobes
   always @(posedge sys_clk) begin
      if (counting) cyc <= cyc + 1;
      if (dut.rx_valid) begin
         strobes   <= strobes + 1;
         last_data <= dut.rx_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      if (cyc > n) check("late_sample", 32'(cyc), 32'(n));
      while (cyc < n) @(negedge sys_clk);
   endtask

   // Pixel (h,v) is registered at edge 2 + 2*(v*800 + h) after release
   task automatic check_pix(input string tag, input int h, input int v, input logic [7:0] exp);
      wait_cyc(2 + 2 * (v * 800 + h));
      check(tag, 32'(rgb), 32'(exp));
   endtask

   // Frame LSB first; abort_at (0..9) raises sys_rst two clocks into that bit
   task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int abort_at);
      logic [9:0] frame;
      logic       aborted;
      frame   = {stop_bit, b, 1'b0};
      aborted = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (!aborted) begin
            rx = frame[i];
            if (i == abort_at) begin
               repeat (2) @(negedge sys_clk);
               sys_rst = 1'b1;
               aborted = 1'b1;
            end else begin
               repeat (5) @(negedge sys_clk);
            end
         end
      end
      if (!aborted) begin
         rx = 1'b1;
         repeat (5) @(negedge sys_clk);
      end
   endtask

   initial begin
      logic [7:0] fill [6];
      fill[0] = 8'h12; fill[1] = 8'h34; fill[2] = 8'h56;
      fill[3] = 8'h78; fill[4] = 8'h9A; fill[5] = 8'hBC;

      // Reset state
      repeat (3) @(negedge sys_clk);
      check("rst_rgb", 32'(rgb), 32'h0);
      check("rst_hsync", 32'(hsync), 32'h0);
      check("rst_vsync", 32'(vsync), 32'h0);
      check("rst_wr_addr", 32'(dut.wr_addr_q), 32'h0);
      sys_rst  = 1'b0;
      counting = 1'b1;

      // Raster timing
      wait_cyc(1);    check("hsync_first_pe", 32'(hsync), 32'h0);
      wait_cyc(2);    check("hsync_rise", 32'(hsync), 32'h1);
                      check("vsync_rise", 32'(vsync), 32'h1);
                      check("rgb_pix_0_0", 32'(rgb), 32'h0);
      wait_cyc(193);  check("hsync_last_hi", 32'(hsync), 32'h1);
      wait_cyc(194);  check("hsync_fall", 32'(hsync), 32'h0);
      wait_cyc(1601); check("hsync_line_end", 32'(hsync), 32'h0);
      wait_cyc(1602); check("hsync_next_line", 32'(hsync), 32'h1);
      wait_cyc(3201); check("vsync_last_hi", 32'(vsync), 32'h1);
      wait_cyc(3202); check("vsync_fall", 32'(vsync), 32'h0);

      // Single byte
      s0 = strobes;
      send_byte(8'hA5, 1'b1, -1);
      check("a5_strobes", 32'(strobes - s0), 32'd1);
      check("a5_data", 32'(last_data), 32'hA5);
      check("a5_mem0", 32'(dut.mem[0]), 32'hA5);
      check("a5_wr_addr", 32'(dut.wr_addr_q), 32'd1);

      // One-clock low glitch
      rx = 1'b0;
      @(negedge sys_clk);
      rx = 1'b1;
      repeat (20) @(negedge sys_clk);
      check("glitch_strobes", 32'(strobes - s0), 32'd1);
      check("glitch_wr_addr", 32'(dut.wr_addr_q), 32'd1);

      // Framing error followed by a good byte
      send_byte(8'h77, 1'b0, -1);
      check("frame_err_strobes", 32'(strobes - s0), 32'd1);
      send_byte(8'h5A, 1'b1, -1);
      check("5a_strobes", 32'(strobes - s0), 32'd2);
      check("5a_mem1", 32'(dut.mem[1]), 32'h5A);
      check("5a_wr_addr", 32'(dut.wr_addr_q), 32'd2);

      // Fill the 8-byte window, wrap, then overwrite address 0
      for (int i = 0; i < 6; i++) send_byte(fill[i], 1'b1, -1);
      check("wrap_wr_addr", 32'(dut.wr_addr_q), 32'd0);
      send_byte(8'h3C, 1'b1, -1);
      check("ovw_mem0", 32'(dut.mem[0]), 32'h3C);
      check("ovw_wr_addr", 32'(dut.wr_addr_q), 32'd1);

      // Image [3C 5A 12 34 / 56 78 9A BC] at h 146..149, v 36..37
      check_pix("above_win", 146, 35, 8'h00);
      check_pix("blank_row36", 10, 36, 8'h00);
      check("hsync_row36", 32'(hsync), 32'h1);
      check_pix("hsync_off_row36", 96, 36, 8'h00);
      check("hsync_low_row36", 32'(hsync), 32'h0);
      check_pix("left_of_win", 145, 36, 8'h00);
      check_pix("win_0_0", 146, 36, 8'h3C);
      check_pix("win_1_0", 147, 36, 8'h5A);
      check_pix("win_3_0", 149, 36, 8'h34);
      check_pix("right_of_win", 150, 36, 8'h00);
      check_pix("win_0_1", 146, 37, 8'h56);
      check_pix("win_3_1", 149, 37, 8'hBC);
      check_pix("below_win", 146, 38, 8'h00);

      // Reset during data bit 4
      counting = 1'b0;
      s0 = strobes;
      send_byte(8'hE1, 1'b1, 5);
      @(negedge sys_clk);
      check("midrst_rgb", 32'(rgb), 32'h0);
      check("midrst_hsync", 32'(hsync), 32'h0);
      check("midrst_vsync", 32'(vsync), 32'h0);
      check("midrst_wr_addr", 32'(dut.wr_addr_q), 32'd0);
      rx = 1'b1;
      repeat (10) @(negedge sys_clk);
      sys_rst = 1'b0;
      repeat (5) @(negedge sys_clk);
      check("midrst_no_strobe", 32'(strobes - s0), 32'd0);
      send_byte(8'hC3, 1'b1, -1);
      check("post_rst_strobes", 32'(strobes - s0), 32'd1);
      check("post_rst_data", 32'(last_data), 32'hC3);
      check("post_rst_mem0", 32'(dut.mem[0]), 32'hC3);
      check("post_rst_wr_addr", 32'(dut.wr_addr_q), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #4_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
